// File: rtl/fp32_pkg.sv
// Shared definitions for the fp32_max_min subsystem: field widths, comparator
// op codes, the sequencer state encoding and a NaN test.
package fp32_pkg;

  localparam int FP32_K = 32;
  localparam int FP32_E = 8;
  localparam int FP32_M = 23;

  localparam int OP_W = 3;
  localparam logic [OP_W-1:0] OP_GTE = 3'd0;
  localparam logic [OP_W-1:0] OP_GT  = 3'd1;
  localparam logic [OP_W-1:0] OP_EQ  = 3'd2;
  localparam logic [OP_W-1:0] OP_LT  = 3'd3;
  localparam logic [OP_W-1:0] OP_LTE = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT1,
    WAIT2,
    DONE
  } seq_state_t;

  function automatic logic is_nan(input logic [FP32_K-1:0] x);
    return (x[FP32_K-2 -: FP32_E] == '1) && (x[FP32_M-1:0] != '0);
  endfunction

endpackage

// File: rtl/FP32_cmp.sv
// Two-cycle registered FP32 comparator. Ordering is total over non-NaN values
// with -0 ranked below +0; any NaN operand forces o_res=0 and raises o_nan_err.
module FP32_cmp
  import fp32_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_valid,
  input  logic [OP_W-1:0]   i_op,
  input  logic [FP32_K-1:0] i_a,
  input  logic [FP32_K-1:0] i_b,
  output logic              o_res_valid,
  output logic              o_res,
  output logic              o_nan_err
);

  logic [FP32_K-1:0] key_a;
  logic [FP32_K-1:0] key_b;
  logic              s1_valid;
  logic              s1_gt;
  logic              s1_eq;
  logic              s1_nan;
  logic [OP_W-1:0]   s1_op;
  logic              s1_res;

  // Map sign-magnitude onto an unsigned key so a plain compare orders floats.
  assign key_a = i_a[FP32_K-1] ? ~i_a : (i_a | {1'b1, {(FP32_K-1){1'b0}}});
  assign key_b = i_b[FP32_K-1] ? ~i_b : (i_b | {1'b1, {(FP32_K-1){1'b0}}});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_gt    <= 1'b0;
      s1_eq    <= 1'b0;
      s1_nan   <= 1'b0;
      s1_op    <= '0;
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_gt  <= key_a > key_b;
        s1_eq  <= key_a == key_b;
        s1_nan <= is_nan(i_a) || is_nan(i_b);
        s1_op  <= i_op;
      end
    end
  end

  always_comb begin
    s1_res = 1'b0;
    case (s1_op)
      OP_GTE:  s1_res = s1_gt | s1_eq;
      OP_GT:   s1_res = s1_gt;
      OP_EQ:   s1_res = s1_eq;
      OP_LT:   s1_res = !s1_gt && !s1_eq;
      OP_LTE:  s1_res = !s1_gt;
      default: s1_res = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_res_valid <= 1'b0;
      o_res       <= 1'b0;
      o_nan_err   <= 1'b0;
    end else begin
      o_res_valid <= s1_valid;
      o_res       <= s1_valid && !s1_nan && s1_res;
      o_nan_err   <= s1_valid && s1_nan;
    end
  end

endmodule

// File: rtl/fp32_maxmin_seq.sv
// Streams a vector of FP32 elements through one shared comparator and returns
// the max or min value with its index; one compare in flight at a time.
module fp32_maxmin_seq
  import fp32_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_valid,
  input  logic [FP32_K-1:0] i_data,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [FP32_K-1:0] o_result,
  output logic [LEN_W-1:0]  o_index,
  output logic              o_nan_err
);

  localparam logic [LEN_W:0] CNT_ONE = 1;
  localparam logic [LEN_W-1:0] LEN_ONE = 1;

  seq_state_t        state;
  seq_state_t        next_state;
  logic              mode;
  logic [LEN_W-1:0]  len;
  logic [LEN_W:0]    cnt;
  logic [LEN_W:0]    cnt_next;
  logic [FP32_K-1:0] best;
  logic [FP32_K-1:0] cand;
  logic [LEN_W-1:0]  idx;
  logic              nan_flag;
  logic              cmp_valid;
  logic              cmp_res_valid;
  logic              cmp_res;
  logic              cmp_nan;

  assign cnt_next = cnt + CNT_ONE;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_start) next_state = (i_len == '0) ? DONE : LOAD;
      LOAD:    if (i_valid) next_state = (len == LEN_ONE) ? DONE : ISSUE;
      ISSUE:   if (i_valid) next_state = WAIT1;
      WAIT1:   next_state = WAIT2;
      WAIT2:   next_state = (cnt_next == {1'b0, len}) ? DONE : ISSUE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_ready   = (state == LOAD) || (state == ISSUE);
    o_busy    = (state != IDLE);
    o_done    = (state == DONE);
    cmp_valid = (state == ISSUE) && i_valid;
  end

  // Result registers are cleared on an accepted start so a zero-length run reports zeros.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode     <= 1'b0;
      len      <= '0;
      cnt      <= '0;
      best     <= '0;
      cand     <= '0;
      idx      <= '0;
      nan_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          mode     <= i_mode;
          len      <= i_len;
          cnt      <= '0;
          best     <= '0;
          idx      <= '0;
          nan_flag <= 1'b0;
        end
        LOAD: if (i_valid) begin
          best     <= i_data;
          idx      <= '0;
          cnt      <= CNT_ONE;
          nan_flag <= is_nan(i_data);
        end
        ISSUE: if (i_valid) cand <= i_data;
        WAIT2: begin
          if (cmp_res_valid) begin
            if (cmp_nan) begin
              nan_flag <= 1'b1;
            end else if (cmp_res) begin
              best <= cand;
              idx  <= cnt[LEN_W-1:0];
            end
          end
          cnt <= cnt_next;
        end
        default: ;
      endcase
    end
  end

  assign o_result  = best;
  assign o_index   = idx;
  assign o_nan_err = nan_flag;

  // Strict compare against the running best keeps the earliest index on ties.
  FP32_cmp u_cmp (
    .clk        (clk),
    .rstn       (rstn),
    .i_valid    (cmp_valid),
    .i_op       (mode ? OP_LT : OP_GT),
    .i_a        (i_data),
    .i_b        (best),
    .o_res_valid(cmp_res_valid),
    .o_res      (cmp_res),
    .o_nan_err  (cmp_nan)
  );

  a_res_valid_in_wait2: assert property (@(posedge clk) disable iff (!rstn)
    (state == WAIT2) |-> cmp_res_valid);

endmodule

// File: tb/tb_fp32_maxmin_seq.sv
// Directed bench for fp32_maxmin_seq: hand-computed results, indices, NaN flag
// and start-to-done latency, plus stalls, ignored starts and a mid-run reset.
module tb_fp32_maxmin_seq;

  logic        clk;
  logic        rstn;
  logic        i_start;
  logic        i_mode;
  logic [7:0]  i_len;
  logic        i_valid;
  logic [31:0] i_data;
  logic        o_ready;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;
  logic [7:0]  o_index;
  logic        o_nan_err;

  int          test_count;
  int          fail_count;
  logic [31:0] vec [8];
  int          lat;
  bit          seen;
  int          done_hits;

  fp32_maxmin_seq #(.LEN_W(8)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .i_start  (i_start),
    .i_mode   (i_mode),
    .i_len    (i_len),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .o_ready  (o_ready),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result),
    .o_index  (o_index),
    .o_nan_err(o_nan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic loadVec(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
    vec[0] = a; vec[1] = b; vec[2] = c; vec[3] = d;
    for (int i = 4; i < 8; i++) vec[i] = 32'h0;
  endtask

  // Runs one vector; returns at the negedge of the o_done cycle with its cycle number.
  task automatic applyStimulus(input logic mode, input logic [7:0] len, input bit gaps,
                               output int done_cyc, output bit got_done);
    int k;
    k = 0;
    got_done = 1'b0;
    done_cyc = -1;
    @(negedge clk);
    i_start = 1'b1;
    i_mode  = mode;
    i_len   = len;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    for (int t = 0; t < 300 && !got_done; t++) begin
      i_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      i_data  = (k < 8) ? vec[k] : 32'hDEADBEEF;
      if (gaps) begin
        i_start = 1'($urandom_range(0, 1));
        i_mode  = ~mode;
        i_len   = 8'd1;
      end
      @(negedge clk);
      if (t == 0) checkOutput("busy_after_start", {31'b0, o_busy}, 32'd1);
      if (o_ready && i_valid) k++;
      if (o_done) begin
        got_done = 1'b1;
        done_cyc = t + 1;
        i_start  = 1'b0;
        i_valid  = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    i_start = 1'b0;
    i_valid = 1'b0;
    if (!got_done) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    test_count = 0;
    fail_count = 0;
    rstn    = 1'b0;
    i_start = 1'b0;
    i_mode  = 1'b0;
    i_len   = 8'd0;
    i_valid = 1'b0;
    i_data  = 32'h0;
    #23;
    checkOutput("rst_ready", {31'b0, o_ready}, 32'd0);
    checkOutput("rst_busy", {31'b0, o_busy}, 32'd0);
    checkOutput("rst_done", {31'b0, o_done}, 32'd0);
    checkOutput("rst_result", o_result, 32'd0);
    checkOutput("rst_index", {24'b0, o_index}, 32'd0);
    checkOutput("rst_nan", {31'b0, o_nan_err}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    loadVec(32'h3F800000, 32'hC0400000, 32'h40000000, 32'h00000000);
    applyStimulus(1'b0, 8'd4, 1'b0, lat, seen);
    checkOutput("max4_result", o_result, 32'h40000000);
    checkOutput("max4_index", {24'b0, o_index}, 32'd2);
    checkOutput("max4_nan", {31'b0, o_nan_err}, 32'd0);
    checkOutput("max4_latency", lat, 32'd11);

    applyStimulus(1'b1, 8'd4, 1'b0, lat, seen);
    checkOutput("min4_result", o_result, 32'hC0400000);
    checkOutput("min4_index", {24'b0, o_index}, 32'd1);
    checkOutput("min4_latency", lat, 32'd11);

    loadVec(32'h40000000, 32'h40000000, 32'h3F800000, 32'h0);
    applyStimulus(1'b0, 8'd3, 1'b0, lat, seen);
    checkOutput("tie_result", o_result, 32'h40000000);
    checkOutput("tie_index", {24'b0, o_index}, 32'd0);
    checkOutput("tie_latency", lat, 32'd8);

    loadVec(32'h80000000, 32'h00000000, 32'h0, 32'h0);
    applyStimulus(1'b0, 8'd2, 1'b0, lat, seen);
    checkOutput("zero_result", o_result, 32'h00000000);
    checkOutput("zero_index", {24'b0, o_index}, 32'd1);
    checkOutput("zero_latency", lat, 32'd5);

    loadVec(32'h3F800000, 32'h7FC00000, 32'h40000000, 32'h0);
    applyStimulus(1'b0, 8'd3, 1'b0, lat, seen);
    checkOutput("nanmid_nan", {31'b0, o_nan_err}, 32'd1);
    checkOutput("nanmid_result", o_result, 32'h40000000);
    checkOutput("nanmid_index", {24'b0, o_index}, 32'd2);

    loadVec(32'h7FC00000, 32'h3F800000, 32'h40000000, 32'h0);
    applyStimulus(1'b0, 8'd3, 1'b0, lat, seen);
    checkOutput("nanfirst_result", o_result, 32'h7FC00000);
    checkOutput("nanfirst_nan", {31'b0, o_nan_err}, 32'd1);
    checkOutput("nanfirst_index", {24'b0, o_index}, 32'd0);

    applyStimulus(1'b0, 8'd0, 1'b0, lat, seen);
    checkOutput("len0_latency", lat, 32'd1);
    checkOutput("len0_result", o_result, 32'd0);
    checkOutput("len0_index", {24'b0, o_index}, 32'd0);
    checkOutput("len0_nan", {31'b0, o_nan_err}, 32'd0);

    loadVec(32'hC0400000, 32'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 8'd1, 1'b0, lat, seen);
    checkOutput("len1_result", o_result, 32'hC0400000);
    checkOutput("len1_index", {24'b0, o_index}, 32'd0);
    checkOutput("len1_latency", lat, 32'd2);

    loadVec(32'h3F000000, 32'h40A00000, 32'hBF800000, 32'h40800000);
    applyStimulus(1'b0, 8'd4, 1'b1, lat, seen);
    checkOutput("gaps_result", o_result, 32'h40A00000);
    checkOutput("gaps_index", {24'b0, o_index}, 32'd1);
    checkOutput("gaps_min_latency", {31'b0, (lat >= 11)}, 32'd1);

    // Abort a run while the first compare sits in WAIT1.
    loadVec(32'h3F800000, 32'hC0400000, 32'h40000000, 32'h00000000);
    @(negedge clk);
    i_start = 1'b1;
    i_mode  = 1'b0;
    i_len   = 8'd4;
    i_valid = 1'b1;
    i_data  = vec[0];
    @(posedge clk);
    #1;
    i_start = 1'b0;
    @(posedge clk);
    #1;
    i_data = vec[1];
    @(posedge clk);
    #1;
    checkOutput("prerst_result", o_result, 32'h3F800000);
    rstn = 1'b0;
    #1;
    checkOutput("midrst_busy", {31'b0, o_busy}, 32'd0);
    checkOutput("midrst_ready", {31'b0, o_ready}, 32'd0);
    checkOutput("midrst_result", o_result, 32'd0);
    checkOutput("midrst_index", {24'b0, o_index}, 32'd0);
    checkOutput("midrst_done", {31'b0, o_done}, 32'd0);
    i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    done_hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_done) done_hits++;
    end
    checkOutput("no_done_after_rst", done_hits, 32'd0);

    applyStimulus(1'b0, 8'd4, 1'b0, lat, seen);
    checkOutput("fresh_result", o_result, 32'h40000000);
    checkOutput("fresh_index", {24'b0, o_index}, 32'd2);
    checkOutput("fresh_latency", lat, 32'd11);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
